// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache controller:
// bus widths, default geometry and the controller state encoding.
package dcache_pkg;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int NLINES_DEF = 8;
    localparam int MM_LAT_DEF = 2;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] S_WRITEBACK = 2'd1;
    localparam logic [STATE_W-1:0] S_ALLOCATE  = 2'd2;
    localparam logic [STATE_W-1:0] S_RESPOND   = 2'd3;

endpackage

// File: rtl/dcache_line_store.sv
// Line storage for the direct-mapped cache: valid/dirty/tag/data per line,
// one write port (which always marks the line valid) and one indexed read port.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int NLINES = NLINES_DEF,
    parameter int IDX_W  = $clog2(NLINES),
    parameter int TAG_W  = ADDR_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [TAG_W-1:0]  wtag,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wdirty,
    input  logic [IDX_W-1:0]  ridx,
    output logic              rvalid,
    output logic              rdirty,
    output logic [TAG_W-1:0]  rtag,
    output logic [DATA_W-1:0] rdata
);

    logic [NLINES-1:0] valid_q;
    logic [NLINES-1:0] dirty_q;
    logic [TAG_W-1:0]  tag_q  [NLINES];
    logic [DATA_W-1:0] data_q [NLINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[widx] <= 1'b1;
            dirty_q[widx] <= wdirty;
        end
    end

    // NOTE: tag/data arrays carry no reset; valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[widx]  <= wtag;
            data_q[widx] <= wdata;
        end
    end

    assign rvalid = valid_q[ridx];
    assign rdirty = dirty_q[ridx];
    assign rtag   = tag_q[ridx];
    assign rdata  = data_q[ridx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate byte cache controller with a
// fixed-latency main-memory strobe interface.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NLINES = NLINES_DEF,
    parameter int MM_LAT = MM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CPURead,
    input  logic              CPUWrite,
    input  logic [ADDR_W-1:0] CPUAddr,
    input  logic [DATA_W-1:0] CPUWData,
    output logic [DATA_W-1:0] CPURData,
    output logic              Stall,
    output logic              MMRead,
    output logic              MMWrite,
    output logic [ADDR_W-1:0] ABUS,
    output logic [DATA_W-1:0] CachetoMem,
    input  logic [DATA_W-1:0] MemtoCache,
    output logic [ADDR_W-1:0] OldTag,
    output logic              CacheSwap
);

    localparam int IDX_W = $clog2(NLINES);
    localparam int TAG_W = ADDR_W - IDX_W;
    localparam int CNT_W = (MM_LAT > 1) ? $clog2(MM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MM_LAT - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  lat_addr_q;
    logic               lat_write_q;
    logic [DATA_W-1:0]  lat_wdata_q;

    logic              req, hit, miss, cnt_last;
    logic [IDX_W-1:0]  cpu_idx, lat_idx, ridx;
    logic [TAG_W-1:0]  cpu_tag, lat_tag;

    logic              we, wdirty;
    logic [IDX_W-1:0]  widx;
    logic [TAG_W-1:0]  wtag;
    logic [DATA_W-1:0] wdata;
    logic              rvalid, rdirty;
    logic [TAG_W-1:0]  rtag;
    logic [DATA_W-1:0] rdata;

    assign req      = CPURead | CPUWrite;
    assign cpu_idx  = CPUAddr[IDX_W-1:0];
    assign cpu_tag  = CPUAddr[ADDR_W-1:IDX_W];
    assign lat_idx  = lat_addr_q[IDX_W-1:0];
    assign lat_tag  = lat_addr_q[ADDR_W-1:IDX_W];
    assign cnt_last = (cnt_q == CNT_LAST);

    // Outside IDLE the line under service is addressed from the latched request.
    assign ridx = (state_q == S_IDLE) ? cpu_idx : lat_idx;
    assign hit  = rvalid && (rtag == cpu_tag);
    assign miss = (state_q == S_IDLE) && req && !hit;

    dcache_line_store #(
        .NLINES (NLINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W)
    ) u_store (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we),
        .widx   (widx),
        .wtag   (wtag),
        .wdata  (wdata),
        .wdirty (wdirty),
        .ridx   (ridx),
        .rvalid (rvalid),
        .rdirty (rdirty),
        .rtag   (rtag),
        .rdata  (rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (miss)
                    state_d = (rvalid && rdirty) ? S_WRITEBACK : S_ALLOCATE;
            end
            S_WRITEBACK: if (cnt_last) state_d = S_ALLOCATE;
            S_ALLOCATE:  if (cnt_last) state_d = S_RESPOND;
            S_RESPOND:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_write_q <= 1'b0;
            lat_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q == S_WRITEBACK || state_q == S_ALLOCATE)
                cnt_q <= cnt_q + 1'b1;
            if (miss) begin
                lat_addr_q  <= CPUAddr;
                lat_write_q <= CPUWrite;
                lat_wdata_q <= CPUWData;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        we     = 1'b0;
        widx   = cpu_idx;
        wtag   = cpu_tag;
        wdata  = CPUWData;
        wdirty = 1'b1;
        if (state_q == S_IDLE && CPUWrite && hit) begin
            we = 1'b1;
        end else if (state_q == S_ALLOCATE && cnt_last) begin
            // A store miss overwrites the fill byte directly with the latched data.
            we     = 1'b1;
            widx   = lat_idx;
            wtag   = lat_tag;
            wdata  = lat_write_q ? lat_wdata_q : MemtoCache;
            wdirty = lat_write_q;
        end
    end

    // Gated by rst_n so a request held through reset cannot raise Stall.
    always_comb begin
        Stall      = 1'b0;
        CPURData   = '0;
        MMRead     = 1'b0;
        MMWrite    = 1'b0;
        CacheSwap  = 1'b0;
        ABUS       = '0;
        OldTag     = '0;
        CachetoMem = '0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (!hit)
                            Stall = 1'b1;
                        else if (!CPUWrite)
                            CPURData = rdata;
                    end
                end
                S_WRITEBACK: begin
                    Stall      = 1'b1;
                    MMWrite    = 1'b1;
                    CacheSwap  = 1'b1;
                    OldTag     = {rtag, lat_idx};
                    CachetoMem = rdata;
                    ABUS       = lat_addr_q;
                end
                S_ALLOCATE: begin
                    Stall  = 1'b1;
                    MMRead = 1'b1;
                    ABUS   = lat_addr_q;
                end
                S_RESPOND: CPURData = rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a byte-level cache model predicts each
// request's outcome; a monitor checks strobes, stall length and load data.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    localparam int NL  = 8;
    localparam int LAT = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       CPURead = 1'b0, CPUWrite = 1'b0;
    logic [7:0] CPUAddr = '0, CPUWData = '0;
    logic [7:0] CPURData, ABUS, CachetoMem, OldTag;
    logic [7:0] MemtoCache = '0;
    logic       Stall, MMRead, MMWrite, CacheSwap;

    dcache_ctrl #(.NLINES(NL), .MM_LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .CPURead    (CPURead),
        .CPUWrite   (CPUWrite),
        .CPUAddr    (CPUAddr),
        .CPUWData   (CPUWData),
        .CPURData   (CPURData),
        .Stall      (Stall),
        .MMRead     (MMRead),
        .MMWrite    (MMWrite),
        .ABUS       (ABUS),
        .CachetoMem (CachetoMem),
        .MemtoCache (MemtoCache),
        .OldTag     (OldTag),
        .CacheSwap  (CacheSwap)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       is_write;
        bit       hit;
        bit       wb;
        bit [7:0] addr;
        bit [7:0] rdata;
        bit [7:0] wb_addr;
        bit [7:0] wb_data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference: which byte address each line holds, plus a reference memory.
    bit       m_valid [NL];
    bit       m_dirty [NL];
    bit [7:0] m_addr  [NL];
    bit [7:0] m_data  [NL];
    bit [7:0] ref_mem  [256];
    bit [7:0] phys_mem [256];

    bit mon_off = 1'b0;
    int stall_n = 0, rd_n = 0, wr_n = 0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input bit w, input bit [7:0] a, input bit [7:0] d);
        exp_t e;
        int   i = int'(a) % NL;
        e.is_write = w;
        e.addr     = a;
        e.hit      = m_valid[i] && m_addr[i] == a;
        e.wb       = 1'b0;
        e.wb_addr  = '0;
        e.wb_data  = '0;
        if (!e.hit) begin
            if (m_valid[i] && m_dirty[i]) begin
                e.wb            = 1'b1;
                e.wb_addr       = m_addr[i];
                e.wb_data       = m_data[i];
                ref_mem[m_addr[i]] = m_data[i];
            end
            m_valid[i] = 1'b1;
            m_addr[i]  = a;
            m_data[i]  = ref_mem[a];
            m_dirty[i] = 1'b0;
        end
        if (w) begin
            m_data[i]  = d;
            m_dirty[i] = 1'b1;
        end
        e.rdata = m_data[i];
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endfunction

    // Main memory: fill data follows ABUS, write-backs land at OldTag.
    always @(negedge clk) begin
        if (MMWrite && CacheSwap)
            phys_mem[OldTag] = CachetoMem;
        MemtoCache = phys_mem[ABUS];
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst_n || mon_off) begin
            stall_n = 0; rd_n = 0; wr_n = 0;
        end else begin
            if (MMRead || MMWrite) begin
                check("strobe_exclusive", {MMRead, MMWrite}, (MMRead ? 2'b10 : 2'b01));
                if (exp_q.size() == 0) begin
                    check("strobe_without_request", 1, 0);
                end else begin
                    check("abus", ABUS, exp_q[0].addr);
                    if (MMRead) rd_n++;
                    if (MMWrite) begin
                        wr_n++;
                        check("cacheswap", CacheSwap, 1);
                        check("oldtag", OldTag, exp_q[0].wb_addr);
                        check("cachetomem", CachetoMem, exp_q[0].wb_data);
                    end
                end
            end
            if (CPURead || CPUWrite) begin
                if (Stall) begin
                    stall_n++;
                end else if (exp_q.size() == 0) begin
                    check("completion_without_request", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("stall_cycles", stall_n, mon_e.hit ? 0 : (1 + LAT + (mon_e.wb ? LAT : 0)));
                    check("mmread_cycles", rd_n, mon_e.hit ? 0 : LAT);
                    check("mmwrite_cycles", wr_n, mon_e.wb ? LAT : 0);
                    if (!mon_e.is_write)
                        check("load_data", CPURData, mon_e.rdata);
                    stall_n = 0; rd_n = 0; wr_n = 0;
                end
            end else begin
                check("idle_outputs", {Stall, MMRead, MMWrite, CacheSwap, CPURData}, 0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic issue(input bit rd, input bit wr, input bit [7:0] a, input bit [7:0] d);
        bit done = 1'b0;
        exp_q.push_back(model(wr, a, d));
        CPURead  = rd;
        CPUWrite = wr;
        CPUAddr  = a;
        CPUWData = d;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (!Stall) done = 1'b1;
        end
        check("request_completes", done, 1);
        @(posedge clk);
        #1;
        CPURead  = 1'b0;
        CPUWrite = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int mism;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]  = 8'($urandom);
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[8'h2A]  = 8'h5C;
        phys_mem[8'h2A] = 8'h5C;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {Stall, MMRead, MMWrite, CacheSwap, ABUS, OldTag, CachetoMem, CPURData}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed sequence: cold load, hit, dirty eviction, store miss, dual request.
        issue(1, 0, 8'h2A, 8'h00);
        issue(1, 0, 8'h2A, 8'h00);
        issue(0, 1, 8'h2A, 8'h33);
        issue(1, 0, 8'h12, 8'h00);
        check("mem_2a_written_back", phys_mem[8'h2A], 8'h33);
        issue(0, 1, 8'h40, 8'h99);
        issue(1, 0, 8'h40, 8'h00);
        issue(1, 1, 8'h05, 8'hA7);
        issue(1, 0, 8'h05, 8'h00);

        // Reset in the first ALLOCATE cycle of a clean miss on 0x2A.
        mon_off  = 1'b1;
        CPURead  = 1'b1;
        CPUAddr  = 8'h2A;
        @(posedge clk);
        #2;
        check("alloc_before_reset", MMRead, 1);
        rst_n = 1'b0;
        #1;
        check("reset_stall", Stall, 0);
        check("reset_strobes", {MMRead, MMWrite, CacheSwap}, 0);
        check("reset_buses", {ABUS, OldTag, CachetoMem, CPURData}, 0);
        CPURead = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_off = 1'b0;
        issue(1, 0, 8'h2A, 8'h00);

        // Randomized traffic over a small address window to force hits and conflicts.
        for (int t = 0; t < 300; t++) begin
            int      op  = $urandom_range(0, 9);
            bit [7:0] a  = (($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'($urandom_range(0, 39)));
            bit [7:0] d  = 8'($urandom);
            int      gap = $urandom_range(0, 2);
            if (op < 5)       issue(1, 0, a, d);
            else if (op < 9)  issue(0, 1, a, d);
            else              issue(1, 1, a, d);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        mism = 0;
        for (int a = 0; a < 256; a++) begin
            int i = a % NL;
            if (!(m_valid[i] && m_dirty[i] && m_addr[i] == 8'(a)) && phys_mem[a] != ref_mem[a])
                mism++;
        end
        check("memory_consistency", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
